// File: rtl/serial_cmp_ctrl_if.sv
// Bundle between a requester, the serial comparison controller and a shared 1-bit
// comparator cell. The controller takes the slave modport; requester and cell take master.
interface serial_cmp_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  // Handshake: start is sampled only while idle; done pulses one cycle with results
  // already valid, and results hold until the next accepted start or reset.
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             G;
  logic             L;
  logic             E;
  logic             err;
  logic [CW-1:0]    cycles;
  logic             cmp_a;
  logic             cmp_b;
  logic             g_in;
  logic             l_in;
  logic             e_in;
  logic [1:0]       fsm_state;

  modport slave (
    input  start, A, B, g_in, l_in, e_in,
    output busy, done, G, L, E, err, cycles, cmp_a, cmp_b, fsm_state
  );

  modport master (
    output start, A, B, g_in, l_in, e_in,
    input  busy, done, G, L, E, err, cycles, cmp_a, cmp_b, fsm_state
  );
endinterface

// File: rtl/serial_cmp_ctrl.sv
// MSB-first serial magnitude comparator controller driving one external 1-bit cell,
// exiting on the first differing bit and flagging a non-one-hot cell response.
module serial_cmp_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              rst,
  serial_cmp_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, a_sh_nxt;
  logic [WIDTH-1:0] b_sh, b_sh_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             g_q, g_nxt;
  logic             l_q, l_nxt;
  logic             e_q, e_nxt;
  logic             err_q, err_nxt;
  logic [CW-1:0]    cycles_q, cycles_nxt;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      cnt      <= '0;
      g_q      <= 1'b0;
      l_q      <= 1'b0;
      e_q      <= 1'b0;
      err_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      state    <= state_nxt;
      a_sh     <= a_sh_nxt;
      b_sh     <= b_sh_nxt;
      cnt      <= cnt_nxt;
      g_q      <= g_nxt;
      l_q      <= l_nxt;
      e_q      <= e_nxt;
      err_q    <= err_nxt;
      cycles_q <= cycles_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    a_sh_nxt   = a_sh;
    b_sh_nxt   = b_sh;
    cnt_nxt    = cnt;
    g_nxt      = g_q;
    l_nxt      = l_q;
    e_nxt      = e_q;
    err_nxt    = err_q;
    cycles_nxt = cycles_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          a_sh_nxt   = bus.A;
          b_sh_nxt   = bus.B;
          cnt_nxt    = '0;
          g_nxt      = 1'b0;
          l_nxt      = 1'b0;
          e_nxt      = 1'b0;
          err_nxt    = 1'b0;
          cycles_nxt = '0;
          state_nxt  = COMPARE;
        end
      end

      COMPARE: begin
        cnt_nxt = cnt + CW'(1);
        case ({bus.g_in, bus.l_in, bus.e_in})
          3'b100: begin
            g_nxt      = 1'b1;
            cycles_nxt = cnt + CW'(1);
            state_nxt  = DONE;
          end
          3'b010: begin
            l_nxt      = 1'b1;
            cycles_nxt = cnt + CW'(1);
            state_nxt  = DONE;
          end
          3'b001: begin
            if (last_bit) begin
              e_nxt      = 1'b1;
              cycles_nxt = CW'(WIDTH);
              state_nxt  = DONE;
            end else begin
              a_sh_nxt = {a_sh[WIDTH-2:0], 1'b0};
              b_sh_nxt = {b_sh[WIDTH-2:0], 1'b0};
            end
          end
          // Zero or several flags: the cell is untrustworthy, so abort with no verdict.
          default: begin
            err_nxt    = 1'b1;
            g_nxt      = 1'b0;
            l_nxt      = 1'b0;
            e_nxt      = 1'b0;
            cycles_nxt = cnt + CW'(1);
            state_nxt  = DONE;
          end
        endcase
      end

      DONE: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy      = (state == COMPARE);
  assign bus.done      = (state == DONE);
  assign bus.cmp_a     = (state == COMPARE) ? a_sh[WIDTH-1] : 1'b0;
  assign bus.cmp_b     = (state == COMPARE) ? b_sh[WIDTH-1] : 1'b0;
  assign bus.G         = g_q;
  assign bus.L         = l_q;
  assign bus.E         = e_q;
  assign bus.err       = err_q;
  assign bus.cycles    = cycles_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed bench for serial_cmp_ctrl with a behavioural 1-bit comparator cell that can
// be forced into a non-one-hot response.
module tb_serial_cmp_ctrl;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cell_fault = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  serial_cmp_ctrl_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  // Behavioural comparator cell; the fault mode asserts both G and L.
  assign bus.g_in = cell_fault ? 1'b1 : (bus.cmp_a & ~bus.cmp_b);
  assign bus.l_in = cell_fault ? 1'b1 : (~bus.cmp_a & bus.cmp_b);
  assign bus.e_in = cell_fault ? 1'b0 : ~(bus.cmp_a ^ bus.cmp_b);

  serial_cmp_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string tag, input logic g, input logic l,
                               input logic e, input logic er, input int cyc);
    check({tag, "_G"}, 32'(bus.G), 32'(g));
    check({tag, "_L"}, 32'(bus.L), 32'(l));
    check({tag, "_E"}, 32'(bus.E), 32'(e));
    check({tag, "_err"}, 32'(bus.err), 32'(er));
    check({tag, "_cycles"}, 32'(bus.cycles), 32'(cyc));
  endtask

  // Accepts one start, scrambles the operand inputs, and waits (bounded) for done.
  task automatic run_cmp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic g, input logic l, input logic e, input int exp_cyc);
    int n;
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.A = ~a;
    bus.B = a;
    check({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
    check({tag, "_clr_e0"}, 32'({bus.G, bus.L, bus.E, bus.err}), 32'd0);
    check({tag, "_cmp_e0"}, 32'({bus.cmp_a, bus.cmp_b}), 32'({a[WIDTH-1], b[WIDTH-1]}));
    n = 0;
    while (!bus.done && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_cyc));
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    check_results(tag, g, l, e, 1'b0, exp_cyc);
    tick();
    check({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
    check({tag, "_hold_G"}, 32'(bus.G), 32'(g));
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_cmp", 32'({bus.cmp_a, bus.cmp_b}), 32'd0);
    check_results("rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    tick();

    // Equal operands, busy held for all 8 bits
    bus.A = 8'hA5;
    bus.B = 8'hA5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.busy) busy_cnt++;
      tick();
    end
    check("eq_busy_cycles", 32'(busy_cnt), 32'd8);
    check("eq_done", 32'(bus.done), 32'd1);
    check_results("eq", 1'b0, 1'b0, 1'b1, 1'b0, 8);
    tick();
    check("eq_done_drop", 32'(bus.done), 32'd0);

    run_cmp("msb_gt", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1);
    run_cmp("lsb_lt", 8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 8);
    run_cmp("bit3_lt", 8'h00, 8'h20, 1'b0, 1'b1, 1'b0, 3);
    run_cmp("bit5_gt", 8'hF8, 8'hF0, 1'b1, 1'b0, 1'b0, 5);

    // Start re-asserted while busy and during done must be ignored
    bus.A = 8'h40;
    bus.B = 8'h10;
    bus.start = 1'b1;
    tick();
    bus.A = 8'h00;
    bus.B = 8'hFF;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done) done_cnt++;
      if (i == 1) check_results("ignore", 1'b1, 1'b0, 1'b0, 1'b0, 2);
    end
    bus.start = 1'b0;
    check("ignore_idle_state", 32'(bus.fsm_state), 32'd0);
    check("ignore_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    if (bus.done) done_cnt++;
    check("ignore_one_done", 32'(done_cnt), 32'd1);
    check_results("ignore_hold", 1'b1, 1'b0, 1'b0, 1'b0, 2);

    // Reset mid-comparison
    bus.A = 8'hFF;
    bus.B = 8'hFF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done) done_cnt++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (bus.done) done_cnt++;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_state", 32'(bus.fsm_state), 32'd0);
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check_results("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    tick();
    check("midrst_stay_idle", 32'(bus.busy), 32'd0);
    run_cmp("post_rst", 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8);

    // Faulty cell on the third bit
    bus.A = 8'h00;
    bus.B = 8'h00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("fault_busy_pre", 32'(bus.busy), 32'd1);
    cell_fault = 1'b1;
    tick();
    cell_fault = 1'b0;
    check("fault_done", 32'(bus.done), 32'd1);
    check_results("fault", 1'b0, 1'b0, 1'b0, 1'b1, 3);
    tick();
    check("fault_done_drop", 32'(bus.done), 32'd0);
    check("fault_err_hold", 32'(bus.err), 32'd1);
    run_cmp("after_fault", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_cmp_ctrl.md
# serial_cmp_ctrl

- Sequences one external `comparator1bit` instance through two WIDTH-bit operands, MSB first, to produce an N-bit magnitude comparison.
- Exits early on the first differing bit.
- Uses a start/done handshake and holds the result until the next start.
- Sits between a requester that supplies operands and a single shared 1-bit comparator cell. It replaces a WIDTH-wide comparator tree where area matters.

## Interface

- `WIDTH`, default 8: operand width in bits; legal range ≥ 2.
- `CW`, default `$clog2(WIDTH+1)`: width of the `cycles` counter.

- `clk`  in  1  : single clock; all state changes on the rising edge.
- `rst`  in  1  : synchronous, active-high reset.
- `start`  in  1  : request; sampled only in IDLE.
- `A`  in  WIDTH  : operand A; captured on the accepted start edge.
- `B`  in  WIDTH  : operand B; captured on the accepted start edge.
- `cmp_a`  out  1  : bit of A presented to the comparator cell.
- `cmp_b`  out  1  : bit of B presented to the comparator cell.
- `g_in`  in  1  : comparator cell output, A>B; combinational return from `cmp_a`/`cmp_b`.
- `l_in`  in  1  : comparator cell output, A<B; combinational return.
- `e_in`  in  1  : comparator cell output, A==B; combinational return.
- `busy`  out  1  : high while in COMPARE.
- `done`  out  1  : one-cycle pulse, high in DONE.
- `G`  out  1  : registered result, A>B.
- `L`  out  1  : registered result, A<B.
- `E`  out  1  : registered result, A==B.
- `err`  out  1  : registered; comparator cell returned a non-one-hot {g_in,l_in,e_in}.
- `cycles`  out  CW  : number of bit comparisons used for the last result.

## Operation

- States: IDLE, COMPARE, DONE.
- Reset, on a rising edge with `rst`=1:
  - state goes to IDLE.
  - `busy`, `done`, `G`, `L`, `E`, `err`, `cycles` all go to 0.
  - Internal shift registers and bit counter are cleared.
  - `rst` has priority over every other input.
- IDLE:
  - On `start`=1, latch A and B into shift registers, clear the bit counter and go to COMPARE.
  - On the same edge, clear `G`/`L`/`E`/`err`/`cycles` to 0.
- COMPARE:
  - `cmp_a`/`cmp_b` equal the current MSB of the A and B shift registers.
  - Each edge evaluates {g_in,l_in,e_in} and increments the bit counter.
  - `g_in`=1 (one-hot): `G`←1, `cycles`←count+1, go to DONE.
  - `l_in`=1 (one-hot): `L`←1, `cycles`←count+1, go to DONE.
  - `e_in`=1 on the last bit (count = WIDTH-1): `E`←1, `cycles`←WIDTH, go to DONE.
  - `e_in`=1 on any other bit: shift both registers left by 1, stay in COMPARE.
  - Not one-hot (zero or several of the three asserted): `err`←1, `G`=`L`=`E`=0, `cycles`←count+1, go to DONE. This aborts the comparison.
- DONE: `done`=1 for exactly one cycle, then return to IDLE unconditionally.
- `cmp_a`/`cmp_b` are driven 0 outside COMPARE.
- `start` is ignored in COMPARE and DONE; no queuing.
- A and B may change freely after the accepted start edge.
- `G`, `L`, `E`, `err` and `cycles` hold their values from DONE until the next accepted start or reset.
- In a non-error result, at most one of `G`/`L`/`E` is 1.

## Timing

- Let edge 0 be the edge on which `start` is accepted.
- Comparison of bit k (k=1 is the MSB) resolves on edge k.
- Latency:
  - Operands first differ at bit position p, counted from the MSB, 1-based: `done` is high during the cycle after edge p, and `cycles`=p.
  - Operands equal: `done` is high after edge WIDTH, and `cycles`=WIDTH.
- Minimum start-to-start spacing is p+2 edges. A start asserted during the `done` cycle is ignored; the next start is accepted in IDLE.
- `busy` rises on edge 0 and falls on the resolving edge.
- Result outputs update on the same edge on which `done` rises.
- Timing paths:
  - `cmp_a`/`cmp_b` → comparator cell → `g_in`/`l_in`/`e_in` is a single-cycle combinational path.
  - No other combinational input-to-output paths exist.
- Reset mid-operation: the next edge returns the block to IDLE with all outputs 0. No `done` pulse is produced. The interrupted result is lost.

## Test plan

Benches use WIDTH=8 with a real `comparator1bit` instance unless stated otherwise.

1. A=8'hA5, B=8'hA5, start → `busy` high for 8 cycles; `done` after edge 8; E=1, G=L=0, cycles=8.
2. A=8'h80, B=8'h7F → resolves on edge 1; G=1, cycles=1; `cmp_a`/`cmp_b`=1/0 during that cycle.
3. A=8'h12, B=8'h13 → resolves on edge 8; L=1, cycles=8. A=8'h00, B=8'h20 → L=1, cycles=3.
4. A=8'h40, B=8'h10, start; re-assert start with A=8'h00, B=8'hFF on edges 1 and 2 and during `done` → only one `done`; G=1, cycles=2; block returns to IDLE.
5. A=8'hFF, B=8'hFF, assert `rst` on edge 4 → edge 4 gives IDLE with `busy`=0, no `done`, all results 0. Then start with A=8'h01, B=8'h00 → G=1, cycles=8.
6. Stub cell replacing the real instance, forcing g_in=l_in=1 on edge 3 with A=B=8'h00 → err=1, G=L=E=0, cycles=3, `done` pulses once. Next start with a correct cell clears `err`.
